// File: rtl/button_event_arbiter_if.sv
// Valid/ready command channel between the button arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
  parameter int unsigned IDX_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_id;

  modport master (
    output cmd_valid,
    output cmd_id,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    output cmd_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Queues one pending event per push-button and offers them round-robin, one at a time,
// to a single consumer; sticky per-button flags record presses lost while already pending.
module button_event_arbiter #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BTN-1:0]              btn_pulse,
  input  logic                          busy,
  input  logic                          clr_overflow,
  output logic [N_BTN-1:0]              overflow,
  button_event_arbiter_if.master        cmd_if
);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e           state_q, state_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] overflow_q, overflow_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0] cmd_id_q, cmd_id_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             handshake;
  logic [N_BTN-1:0] grant_clr;
  logic [N_BTN-1:0] ovf_set;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign handshake = cmd_valid_q & cmd_if.cmd_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      grant_clr[i] = handshake && (cmd_id_q == IDX_W'(i));
    end
  end

  // A new press beats a same-cycle grant clear and is not counted as lost.
  always_comb begin
    ovf_set    = btn_pulse & pending_q & ~grant_clr;
    pending_d  = btn_pulse | (pending_q & ~grant_clr);
    overflow_d = ovf_set | (clr_overflow ? '0 : overflow_q);
  end

  // Round-robin search starting just after the last granted index, wrapping modulo N_BTN.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      cand = 32'(last_grant_q) + k;
      if (cand >= N_BTN) begin
        cand = cand - N_BTN;
      end
      if (!pick_found && (|(pending_q & (N_BTN'(1) << cand)))) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (!busy && pick_found) begin
          cmd_id_d    = pick_idx;
          cmd_valid_d = 1'b1;
          state_d     = StOffer;
        end else begin
          cmd_valid_d = 1'b0;
        end
      end
      StOffer: begin
        // busy is deliberately ignored here: an offer once made is never withdrawn.
        if (cmd_if.cmd_ready) begin
          cmd_valid_d  = 1'b0;
          last_grant_d = cmd_id_q;
          state_d      = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      overflow_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      last_grant_q <= IDX_W'(N_BTN - 1);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_id    = cmd_id_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Table-driven bench for button_event_arbiter: per-cycle vectors with expected outputs
// queued on drive and compared one cycle later, plus a hand-written busy-gating sequence.
module tb_button_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       busy;
  logic       clr_overflow;
  logic [3:0] overflow;

  button_event_arbiter_if #(.IDX_W(2)) cif ();

  button_event_arbiter #(
    .N_BTN(4),
    .IDX_W(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pulse   (btn_pulse),
    .busy        (busy),
    .clr_overflow(clr_overflow),
    .overflow    (overflow),
    .cmd_if      (cif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] btn;
    logic       busy;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string n, input logic r, input logic [3:0] b, input logic bz,
                     input logic rd, input logic cl, input logic ev, input logic [1:0] eid,
                     input logic [3:0] eo);
    vec_t v;
    v.name = n; v.rst = r; v.btn = b; v.busy = bz; v.ready = rd; v.clr = cl;
    v.exp_valid = ev; v.exp_id = eid; v.exp_ovf = eo;
    tbl.push_back(v);
  endtask

  task automatic check(input vec_t e);
    n_vec++;
    if (cif.cmd_valid !== e.exp_valid) begin
      n_bad++;
      $display("FAIL %s: cmd_valid=%b expected %b", e.name, cif.cmd_valid, e.exp_valid);
    end else if (e.exp_valid && (cif.cmd_id !== e.exp_id)) begin
      n_bad++;
      $display("FAIL %s: cmd_id=%0d expected %0d", e.name, cif.cmd_id, e.exp_id);
    end
    if (overflow !== e.exp_ovf) begin
      n_bad++;
      $display("FAIL %s: overflow=%b expected %b", e.name, overflow, e.exp_ovf);
    end
  endtask

  task automatic apply(input vec_t v);
    rst           = v.rst;
    btn_pulse     = v.btn;
    busy          = v.busy;
    cif.cmd_ready = v.ready;
    clr_overflow  = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(sb.pop_front());
  endtask

  task automatic step(input string n, input logic bz, input logic rd, input logic [3:0] b,
                      input logic ev, input logic [1:0] eid);
    vec_t v;
    v.name = n; v.rst = 1'b1; v.btn = b; v.busy = bz; v.ready = rd; v.clr = 1'b0;
    v.exp_valid = ev; v.exp_id = eid; v.exp_ovf = 4'b0000;
    apply(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  split;
    bit  seen;

    rst = 1'b0; btn_pulse = '0; busy = 1'b0; clr_overflow = 1'b0; cif.cmd_ready = 1'b0;

    // Reset with all buttons pulsing; nothing survives release.
    add("rst_hold",    0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000);
    add("rst_hold",    0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000);
    add("rst_release", 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("rst_idle",    1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("rst_idle",    1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // Single press of button 2: offer two cycles after the pulse.
    add("single_press", 1, 4'b0100, 0, 1, 0, 0, 0, 4'b0000);
    add("single_offer", 1, 4'b0000, 0, 1, 0, 1, 2, 4'b0000);
    add("single_done",  1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add("single_done",  1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    // Round-robin from reset: 0,1,2,3 on alternating cycles.
    add("rr_rst",   0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("rr_press", 1, 4'b1111, 0, 1, 0, 0, 0, 4'b0000);
    for (int g = 0; g < 4; g++) begin
      add("rr_offer", 1, 4'b0000, 0, 1, 0, 1, 2'(g), 4'b0000);
      add("rr_done",  1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    end
    // Last grant was 3, so 0 wins over 3.
    add("pair_press",  1, 4'b1001, 0, 1, 0, 0, 0, 4'b0000);
    add("pair_first",  1, 4'b0000, 0, 1, 0, 1, 0, 4'b0000);
    add("pair_done",   1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add("pair_second", 1, 4'b0000, 0, 1, 0, 1, 3, 4'b0000);
    add("pair_done",   1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    split = tbl.size();
    // Overflow on button 3; clear loses to a simultaneous set.
    add("ovf_press1",  1, 4'b1000, 0, 0, 0, 0, 0, 4'b0000);
    add("ovf_press2",  1, 4'b1000, 0, 0, 0, 1, 3, 4'b1000);
    add("ovf_clr_set", 1, 4'b1000, 0, 0, 1, 1, 3, 4'b1000);
    add("ovf_clr",     1, 4'b0000, 0, 0, 1, 1, 3, 4'b0000);
    add("ovf_take",    1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add("ovf_idle",    1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // Handshake on id 1 together with a new press of button 1.
    add("cs_press",   1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000);
    add("cs_offer",   1, 4'b0000, 0, 0, 0, 1, 1, 4'b0000);
    add("cs_hs_set",  1, 4'b0010, 0, 1, 0, 0, 0, 4'b0000);
    add("cs_regrant", 1, 4'b0000, 0, 0, 0, 1, 1, 4'b0000);
    add("cs_done",    1, 4'b0000, 0, 1, 0, 0, 0, 4'b0000);
    add("cs_idle",    1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // Reset during an offer: the event is dropped, not replayed.
    add("mo_press",     1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
    add("mo_offer",     1, 4'b0000, 0, 0, 0, 1, 0, 4'b0000);
    add("mo_rst",       0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("mo_release",   1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("mo_no_replay", 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    add("mo_no_replay", 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);

    for (int i = 0; i < split; i++) apply(tbl[i]);

    // Busy gating: press 1 while busy, nothing offered for 10 cycles.
    step("busy_press", 1, 1, 4'b0010, 0, 0);
    for (int c = 0; c < 10; c++) step("busy_hold", 1, 1, 4'b0000, 0, 0);
    busy = 1'b0;
    cif.cmd_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (cif.cmd_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || cif.cmd_id !== 2'd1) begin
      n_bad++;
      $display("FAIL busy_release: cmd_valid=%b cmd_id=%0d expected 1 and 1 within 2 cycles",
               cif.cmd_valid, cif.cmd_id);
    end
    // busy rising mid-offer does not withdraw it.
    for (int c = 0; c < 3; c++) step("busy_mid_offer", 1, 0, 4'b0000, 1, 1);
    step("busy_hs", 1, 1, 4'b0000, 0, 0);
    step("busy_after", 0, 0, 4'b0000, 0, 0);

    for (int i = split; i < tbl.size(); i++) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
